// File: rtl/usb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_bridge_pkg
// Purpose  : Shared constants, tx state encoding and byte helper for the
//            USB UART bridge.
// Revision : 1.0 - initial release
// ============================================================================
package usb_bridge_pkg;

  localparam logic [7:0] SYNC0            = 8'h00;
  localparam logic [7:0] SYNC1            = 8'hAA;
  localparam logic [7:0] SYNC2            = 8'hFF;
  localparam logic [7:0] CMD_WRITE_A      = 8'h01;
  localparam logic [7:0] CMD_WRITE_B      = 8'h02;
  localparam logic [7:0] RESP_CMD_DEFAULT = 8'h81;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_SYNC0 = 3'd1,
    TX_SYNC1 = 3'd2,
    TX_SYNC2 = 3'd3,
    TX_CMD   = 3'd4,
    TX_LEN   = 3'd5,
    TX_DATA  = 3'd6
  } tx_state_e;

  // Byte 0 is the most significant byte: words go out MSB-first.
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] sel);
    sel_byte = word[7:0];
    case (sel)
      2'd0:    sel_byte = word[31:24];
      2'd1:    sel_byte = word[23:16];
      2'd2:    sel_byte = word[15:8];
      default: sel_byte = word[7:0];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : usb_word_fifo
// Purpose  : First-word-fall-through word FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module usb_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         rd_data_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [CW-1:0] c_cnt_max = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_ptr_nxt;

  assign full         = (r_count == c_cnt_max);
  assign empty        = (r_count == '0);
  assign count        = r_count;
  assign w_push       = push && !full;
  assign w_pop        = pop && !empty;
  assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
  assign rd_data      = r_mem[r_rd_ptr];
  // Lets the consumer preload the following word on the same edge as a pop.
  assign rd_data_next = r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_uart_readback_tx.sv
`default_nettype none
// ============================================================================
// Module   : usb_uart_readback_tx
// Purpose  : Buffers fabric words and frames them as 00 AA FF / CMD / LEN /
//            payload byte packets on the USB IN byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module usb_uart_readback_tx
  import usb_bridge_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] RESP_CMD   = RESP_CMD_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  tx_state_e        r_state;
  logic [7:0]       r_in_data;
  logic             r_in_valid;
  logic [CNT_W-1:0] r_frame_words;
  logic [CNT_W-1:0] r_words_left;
  logic [1:0]       r_byte_sel;

  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_head;
  logic [31:0]      w_head_next;
  logic             w_push;
  logic             w_pop;
  logic             w_hs;
  logic             w_last_byte;
  logic [CNT_W-1:0] w_count_after;

  assign word_ready_o = !w_full;
  assign w_push       = word_valid_i && !w_full;
  assign w_hs         = r_in_valid && in_ready_i;
  assign w_last_byte  = (r_state == TX_DATA) && w_hs && (r_byte_sel == 2'd3);
  assign w_pop        = w_last_byte;
  // Occupancy once this edge's pop and push have landed; seeds the next frame.
  assign w_count_after = w_count - c_cnt_one + CNT_W'(w_push);

  assign in_data_o  = r_in_data;
  assign in_valid_o = r_in_valid;
  assign busy_o     = (r_state != TX_IDLE);

  usb_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .push         (w_push),
    .pop          (w_pop),
    .wr_data      (word_i),
    .rd_data      (w_head),
    .rd_data_next (w_head_next),
    .full         (w_full),
    .empty        (w_empty),
    .count        (w_count)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= TX_IDLE;
      r_in_data     <= 8'h00;
      r_in_valid    <= 1'b0;
      r_frame_words <= '0;
      r_words_left  <= '0;
      r_byte_sel    <= 2'd0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (!w_empty) begin
            r_state       <= TX_SYNC0;
            r_frame_words <= w_count;
            r_in_valid    <= 1'b1;
            r_in_data     <= SYNC0;
          end
        end
        TX_SYNC0: begin
          if (w_hs) begin
            r_state   <= TX_SYNC1;
            r_in_data <= SYNC1;
          end
        end
        TX_SYNC1: begin
          if (w_hs) begin
            r_state   <= TX_SYNC2;
            r_in_data <= SYNC2;
          end
        end
        TX_SYNC2: begin
          if (w_hs) begin
            r_state   <= TX_CMD;
            r_in_data <= RESP_CMD;
          end
        end
        TX_CMD: begin
          if (w_hs) begin
            r_state   <= TX_LEN;
            r_in_data <= 8'(r_frame_words);
          end
        end
        TX_LEN: begin
          if (w_hs) begin
            r_state      <= TX_DATA;
            r_in_data    <= sel_byte(w_head, 2'd0);
            r_byte_sel   <= 2'd0;
            r_words_left <= r_frame_words;
          end
        end
        TX_DATA: begin
          if (w_hs) begin
            if (r_byte_sel != 2'd3) begin
              r_byte_sel <= r_byte_sel + 2'd1;
              r_in_data  <= sel_byte(w_head, r_byte_sel + 2'd1);
            end else begin
              r_words_left <= r_words_left - c_cnt_one;
              r_byte_sel   <= 2'd0;
              if (r_words_left == c_cnt_one) begin
                if (w_count_after != '0) begin
                  r_state       <= TX_SYNC0;
                  r_frame_words <= w_count_after;
                  r_in_data     <= SYNC0;
                end else begin
                  r_state    <= TX_IDLE;
                  r_in_valid <= 1'b0;
                end
              end else begin
                // Words of the current frame are already resident, so the
                // follower is valid in the FIFO while the head is popped.
                r_in_data <= sel_byte(w_head_next, 2'd0);
              end
            end
          end
        end
        default: begin
          r_state    <= TX_IDLE;
          r_in_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_uart_readback_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_uart_readback_tx
// Purpose  : Scoreboard bench for usb_uart_readback_tx (default and a
//            4-deep / CMD 82 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_uart_readback_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] word0, word1;
  logic        wv0, wv1, wr0, wr1;
  logic [7:0]  d0, d1;
  logic        v0, v1, rdy0, rdy1, busy0, busy1;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          hs_log[$];
  logic        thr_en   = 1'b0;
  logic        rdy_lvl0 = 1'b1;
  logic        rdy_lvl1 = 1'b1;

  usb_uart_readback_tx dut (
    .clk_i(clk), .reset_n_i(reset_n), .word_i(word0), .word_valid_i(wv0),
    .word_ready_o(wr0), .in_data_o(d0), .in_valid_o(v0), .in_ready_i(rdy0),
    .busy_o(busy0)
  );

  usb_uart_readback_tx #(.FIFO_DEPTH(4), .RESP_CMD(8'h82)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .word_i(word1), .word_valid_i(wv1),
    .word_ready_o(wr1), .in_data_o(d1), .in_valid_o(v1), .in_ready_i(rdy1),
    .busy_o(busy1)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Endpoint ready driver: fixed level or ~50% random throttle.
  initial begin
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy0 = thr_en ? ($urandom_range(0, 1) == 1) : rdy_lvl0;
      rdy1 = rdy_lvl1;
    end
  end

  // Monitor: pops the scoreboard on every byte handshake, checks stall hold.
  initial begin
    logic       sp [2];
    logic [7:0] pd [2];
    logic       v, r;
    logic [7:0] d, e;
    sp[0] = 1'b0; sp[1] = 1'b0; pd[0] = 8'h00; pd[1] = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sp[0] = 1'b0;
        sp[1] = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          v = (i == 0) ? v0 : v1;
          r = (i == 0) ? rdy0 : rdy1;
          d = (i == 0) ? d0 : d1;
          if (sp[i]) begin
            n_vec++;
            if (!v || d != pd[i]) begin
              n_err++;
              $display("FAIL stall_hold dut%0d: got valid=%0b data=%02h, required valid=1 data=%02h",
                       i, v, d, pd[i]);
            end
          end
          if (v && r) begin
            n_vec++;
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
              n_err++;
              $display("FAIL unexpected_byte dut%0d: got %02h, required no byte", i, d);
            end else begin
              e = (i == 0) ? q0.pop_front() : q1.pop_front();
              if (d != e) begin
                n_err++;
                $display("FAIL byte dut%0d: got %02h, required %02h", i, d, e);
              end
            end
            if (i == 0) hs_log.push_back(cyc);
          end
          sp[i] = v && !r;
          pd[i] = d;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic exp_byte(input int id, input logic [7:0] b);
    if (id == 0) q0.push_back(b);
    else         q1.push_back(b);
  endtask

  task automatic add_hdr(input int id, input logic [7:0] cmd, input logic [7:0] len);
    exp_byte(id, 8'h00); exp_byte(id, 8'hAA); exp_byte(id, 8'hFF);
    exp_byte(id, cmd);   exp_byte(id, len);
  endtask

  task automatic add_word(input int id, input logic [31:0] w);
    exp_byte(id, w[31:24]); exp_byte(id, w[23:16]);
    exp_byte(id, w[15:8]);  exp_byte(id, w[7:0]);
  endtask

  // Called just after a posedge; returns just after the push edge.
  task automatic push(input int id, input logic [31:0] w, output logic acc);
    if (id == 0) begin wv0 = 1'b1; word0 = w; end
    else         begin wv1 = 1'b1; word1 = w; end
    @(negedge clk);
    acc = (id == 0) ? wr0 : wr1;
    @(posedge clk);
    #1;
    if (id == 0) wv0 = 1'b0;
    else         wv1 = 1'b0;
  endtask

  task automatic drain(input int id, input int max_cyc);
    int n = 0;
    while (((id == 0) ? q0.size() : q1.size()) != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("drain_left_dut%0d", id), (id == 0) ? q0.size() : q1.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   n_acc;
    int   n;
    logic [31:0] w;

    reset_n = 1'b0; wv0 = 1'b0; wv1 = 1'b0; word0 = '0; word1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid",  v0, 0);
    chk("reset_data",   d0, 8'h00);
    chk("reset_busy",   busy0, 0);
    chk("reset_ready",  wr0, 1);
    chk("reset_ready2", wr1, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single word: 9 back-to-back bytes, first one a cycle after the push.
    add_hdr(0, 8'h81, 8'h01); add_word(0, 32'hDEADBEEF);
    hs_log.delete();
    push(0, 32'hDEADBEEF, acc);
    chk("t1_accepted", acc, 1);
    @(negedge clk);
    chk("t1_valid_k", v0, 0);
    @(negedge clk);
    chk("t1_valid_k1", v0, 1);
    chk("t1_first_byte", d0, 8'h00);
    drain(0, 40);
    chk("t1_busy_after", busy0, 0);
    chk("t1_nbytes", hs_log.size(), 9);
    if (hs_log.size() == 9) chk("t1_no_bubble", hs_log[8] - hs_log[0], 8);
    @(posedge clk); #1;

    // Three consecutive pushes: frames of 1 then 2 words, no gap between.
    add_hdr(0, 8'h81, 8'h01); add_word(0, 32'h11223344);
    add_hdr(0, 8'h81, 8'h02); add_word(0, 32'h55667788); add_word(0, 32'h99AABBCC);
    hs_log.delete();
    push(0, 32'h11223344, acc);
    push(0, 32'h55667788, acc);
    push(0, 32'h99AABBCC, acc);
    drain(0, 60);
    chk("t2_nbytes", hs_log.size(), 22);
    if (hs_log.size() == 22) chk("t2_no_gap", hs_log[21] - hs_log[0], 21);
    @(posedge clk); #1;

    // Same shape under random endpoint throttling.
    thr_en = 1'b1;
    add_hdr(0, 8'h81, 8'h01); add_word(0, 32'hA1B2C3D4);
    add_hdr(0, 8'h81, 8'h02); add_word(0, 32'hE5F60718); add_word(0, 32'h0F1E2D3C);
    push(0, 32'hA1B2C3D4, acc);
    push(0, 32'hE5F60718, acc);
    push(0, 32'h0F1E2D3C, acc);
    drain(0, 400);
    thr_en = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Endpoint stalled: FIFO fills at 8, overflow pushes refused.
    rdy_lvl0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      w = 32'h10203040 + 32'h01010101 * i;
      push(0, w, acc);
      if (acc) begin
        if (n_acc == 0) add_hdr(0, 8'h81, 8'h01);
        add_word(0, w);
        if (n_acc == 0) add_hdr(0, 8'h81, 8'h07);
        n_acc++;
      end
    end
    chk("t4_accepted", n_acc, 8);
    @(negedge clk);
    chk("t4_ready_low", wr0, 0);
    chk("t4_stalled_valid", v0, 1);
    chk("t4_stalled_data", d0, 8'h00);
    @(posedge clk); #1;
    rdy_lvl0 = 1'b1;
    drain(0, 200);
    chk("t4_idle", busy0, 0);
    @(posedge clk); #1;

    // Reset in the middle of the payload.
    add_hdr(0, 8'h81, 8'h01); add_word(0, 32'h12345678);
    push(0, 32'h12345678, acc);
    n = 0;
    while (!(v0 && d0 == 8'h34) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_data", n < 30, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_valid_drop", v0, 0);
    chk("t5_ready", wr0, 1);
    chk("t5_busy", busy0, 0);
    q0.delete();
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_quiet", v0, 0);
    @(posedge clk); #1;
    add_hdr(0, 8'h81, 8'h01); add_word(0, 32'hCAFEF00D);
    push(0, 32'hCAFEF00D, acc);
    @(negedge clk);
    @(negedge clk);
    chk("t5_fresh_sync", d0, 8'h00);
    drain(0, 40);

    // 4-deep instance, CMD 82: fill while stalled, then release.
    rdy_lvl1 = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      w = 32'hC0000000 + 32'h00110011 * i;
      push(1, w, acc);
      if (acc) begin
        if (n_acc == 0) add_hdr(1, 8'h82, 8'h01);
        add_word(1, w);
        if (n_acc == 0) add_hdr(1, 8'h82, 8'h03);
        n_acc++;
      end
    end
    chk("t6_accepted", n_acc, 4);
    @(negedge clk);
    chk("t6_ready_low", wr1, 0);
    @(posedge clk); #1;
    rdy_lvl1 = 1'b1;
    drain(1, 100);
    chk("t6_idle", busy1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
